mul4_seq_ctrl: RTL and testbench

Sequencing front-end for the 4x4 shift-add multiplier datapath. It accepts operand pairs over a valid/ready handshake and drives the multiplier's A/B/START inputs. It waits for the multiplier's READY, captures the 8-bit product, and presents results through a small result FIFO with its own valid/ready handshake. It also detects a hung multiplier with a watchdog and reports it.

---
 rtl/mul4_seq_ctrl_if.sv | 39 +++
 rtl/mul4_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mul4_seq_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul4_seq_ctrl_if.sv
// Bundle of the operand, multiplier and result handshakes around mul4_seq_ctrl.
// The slave view is the controller itself; the master view is its environment
// (operand source, multiplier datapath and result consumer).
interface mul4_seq_ctrl_if;
    // Operand input handshake
    logic       IN_VALID;
    logic       IN_READY;
    logic [3:0] IN_A;
    logic [3:0] IN_B;

    // Shift-add multiplier side
    logic       MUL_START;
    logic [3:0] MUL_A;
    logic [3:0] MUL_B;
    logic       MUL_READY;
    logic [7:0] MUL_P;

    // Result output handshake
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] OUT_P;
    logic       OUT_ERR;

    // Status
    logic       BUSY;
    logic [7:0] ERR_CNT;

    modport slave (
        input  IN_VALID, IN_A, IN_B, MUL_READY, MUL_P, OUT_READY,
        output IN_READY, MUL_START, MUL_A, MUL_B, OUT_VALID, OUT_P, OUT_ERR,
               BUSY, ERR_CNT
    );

    modport master (
        output IN_VALID, IN_A, IN_B, MUL_READY, MUL_P, OUT_READY,
        input  IN_READY, MUL_START, MUL_A, MUL_B, OUT_VALID, OUT_P, OUT_ERR,
               BUSY, ERR_CNT
    );
endinterface

// File: rtl/mul4_seq_ctrl.sv
// Sequencing front-end for the 4x4 shift-add multiplier. Accepts one operand
// pair at a time, pulses START, waits out a settle cycle (READY may still be
// high from the previous job), captures the product or a watchdog error entry
// into a small result FIFO, and counts timeouts with a saturating counter.
module mul4_seq_ctrl #(
    parameter int RES_DEPTH = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic CK,
    input  logic RSTN,
    mul4_seq_ctrl_if.slave bus
);

    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    // Saturating increment for the timeout counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    // Wrapping pointer increment; depth is a power of two so truncation wraps.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    state_t            state_q,     state_d;
    logic [3:0]        mul_a_q,     mul_a_d;
    logic [3:0]        mul_b_q,     mul_b_d;
    logic              mul_start_q, mul_start_d;
    logic              busy_q,      busy_d;
    logic [7:0]        err_cnt_q,   err_cnt_d;
    logic [7:0]        wdog_q,      wdog_d;
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]  count_q,     count_d;

    // FIFO entry layout: {err, product}
    logic [8:0]        mem_q [RES_DEPTH];
    logic [8:0]        mem_d [RES_DEPTH];

    logic              in_ready;
    logic              accept;
    logic              out_valid;
    logic              pop;
    logic              push;
    logic [8:0]        push_entry;

    // Handshake decode from the current state and FIFO occupancy.
    always_comb begin
        in_ready  = (state_q == IDLE) && (count_q < CNT_W'(RES_DEPTH));
        accept    = bus.IN_VALID && in_ready;
        out_valid = (count_q != '0);
        pop       = out_valid && bus.OUT_READY;
    end

    // Job sequencing: next state, operand latch, start pulse, watchdog and capture.
    always_comb begin
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_start_d = 1'b0;
        wdog_d      = wdog_q;
        err_cnt_d   = err_cnt_q;
        push        = 1'b0;
        push_entry  = 9'd0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mul_a_d     = bus.IN_A;
                    mul_b_d     = bus.IN_B;
                    mul_start_d = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                // READY is not trusted here: it may be left over from the last job.
                wdog_d  = 8'd0;
                state_d = RUN;
            end
            RUN: begin
                if (bus.MUL_READY) begin
                    push       = 1'b1;
                    push_entry = {1'b0, bus.MUL_P};
                    state_d    = IDLE;
                end else if (wdog_q == 8'(TIMEOUT - 1)) begin
                    push       = 1'b1;
                    push_entry = {1'b1, 8'h00};
                    err_cnt_d  = sat_inc8(err_cnt_q);
                    state_d    = IDLE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Result FIFO bookkeeping; a push always has a free slot because jobs are
    // only accepted while the FIFO has room.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and status registers, cleared asynchronously.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            mul_a_q     <= 4'd0;
            mul_b_q     <= 4'd0;
            mul_start_q <= 1'b0;
            busy_q      <= 1'b0;
            err_cnt_q   <= 8'd0;
            wdog_q      <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
            busy_q      <= busy_d;
            err_cnt_q   <= err_cnt_d;
            wdog_q      <= wdog_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents are only observed through a valid head, so no reset.
    always_ff @(posedge CK) begin
        mem_q <= mem_d;
    end

    assign bus.IN_READY  = in_ready;
    assign bus.MUL_START = mul_start_q;
    assign bus.MUL_A     = mul_a_q;
    assign bus.MUL_B     = mul_b_q;
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_P     = out_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
    assign bus.OUT_ERR   = out_valid ? mem_q[rd_ptr_q][8]   : 1'b0;
    assign bus.BUSY      = busy_q;
    assign bus.ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// Directed bench for mul4_seq_ctrl with a behavioural shift-add multiplier
// model and a result scoreboard fed at operand acceptance.
module tb_mul4_seq_ctrl;

    logic CK = 1'b0;
    logic RSTN;

    mul4_seq_ctrl_if bus ();

    mul4_seq_ctrl #(.RES_DEPTH(2), .TIMEOUT(15)) dut (
        .CK   (CK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    always #5 CK = ~CK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [8:0] sb[$];
    int         pop_cyc[$];

    // Multiplier model controls
    logic hung       = 1'b0;
    logic hold_stale = 1'b0;
    int   lat        = 5;

    logic       m_rdy = 1'b0;
    logic [7:0] m_p   = 8'h00;
    logic [7:0] pend_p = 8'h00;
    int         dly   = 0;
    int         keep  = 0;

    assign bus.MUL_READY = m_rdy & ~hung;
    assign bus.MUL_P     = m_p;

    function automatic logic [7:0] prod8(input logic [3:0] a, input logic [3:0] b);
        return {4'd0, a} * {4'd0, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge CK) cyc <= cyc + 1;

    // Behavioural multiplier: READY rises lat+1 cycles after the START cycle and
    // stays high until the next START (or two cycles later in stale mode).
    always @(posedge CK) begin
        if (bus.MUL_START) begin
            pend_p <= prod8(bus.MUL_A, bus.MUL_B);
            dly    <= lat;
            if (hold_stale) begin
                keep <= 1;
            end else begin
                m_rdy <= 1'b0;
                m_p   <= 8'hA5;
            end
        end else begin
            if (keep == 1) begin
                keep  <= 0;
                m_rdy <= 1'b0;
            end
            if (dly == 1) begin
                m_rdy <= 1'b1;
                m_p   <= pend_p;
            end
            if (dly > 0) dly <= dly - 1;
        end
    end

    // Scoreboard: push on accept, pop and compare on result handshake.
    always @(negedge CK) begin
        #2;
        if (RSTN) begin
            if (bus.IN_VALID && bus.IN_READY)
                sb.push_back(hung ? 9'h100 : {1'b0, prod8(bus.IN_A, bus.IN_B)});
            if (bus.OUT_VALID && bus.OUT_READY) begin
                check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    check("result", {23'd0, bus.OUT_ERR, bus.OUT_P}, {23'd0, e});
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(negedge CK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Offer a pair, wait (bounded) for acceptance; returns in the cycle after accept.
    task automatic offer(input logic [3:0] a, input logic [3:0] b, input int bound,
                         output int acc);
        int k;
        k = 0;
        bus.IN_A     = a;
        bus.IN_B     = b;
        bus.IN_VALID = 1'b1;
        while (!bus.IN_READY && k < bound) begin
            tick();
            k++;
        end
        check("accept_wait", 32'(bus.IN_READY), 32'd1);
        acc = cyc;
        tick();
        bus.IN_VALID = 1'b0;
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while (sb.size() != 0 && k < bound) begin
            tick();
            k++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cycles=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int a0, a1, a2, acc;
        logic rose;

        RSTN          = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.IN_A      = 4'd0;
        bus.IN_B      = 4'd0;
        bus.OUT_READY = 1'b0;
        ticks(3);

        // Reset state
        check("rst_mul_start", 32'(bus.MUL_START), 32'd0);
        check("rst_mul_a",     32'(bus.MUL_A),     32'd0);
        check("rst_mul_b",     32'(bus.MUL_B),     32'd0);
        check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        check("rst_out_p",     32'(bus.OUT_P),     32'd0);
        check("rst_out_err",   32'(bus.OUT_ERR),   32'd0);
        check("rst_busy",      32'(bus.BUSY),      32'd0);
        check("rst_err_cnt",   32'(bus.ERR_CNT),   32'd0);
        RSTN = 1'b1;
        tick();
        check("first_in_ready", 32'(bus.IN_READY), 32'd1);

        // Single job 13 x 11 with immediate pop
        bus.OUT_READY = 1'b1;
        bus.IN_A = 4'd13; bus.IN_B = 4'd11; bus.IN_VALID = 1'b1;
        check("t1_in_ready_n", 32'(bus.IN_READY), 32'd1);
        tick();                                   // N+1
        bus.IN_VALID = 1'b0;
        check("t1_start_n1", 32'(bus.MUL_START), 32'd1);
        check("t1_mul_a",    32'(bus.MUL_A),     32'd13);
        check("t1_mul_b",    32'(bus.MUL_B),     32'd11);
        check("t1_busy",     32'(bus.BUSY),      32'd1);
        tick();                                   // N+2
        check("t1_start_n2", 32'(bus.MUL_START), 32'd0);
        ticks(5);                                 // N+7
        check("t1_valid_n7", 32'(bus.OUT_VALID), 32'd0);
        tick();                                   // N+8
        check("t1_valid_n8", 32'(bus.OUT_VALID), 32'd1);
        check("t1_out_p",    32'(bus.OUT_P),     32'h8F);
        check("t1_out_err",  32'(bus.OUT_ERR),   32'd0);
        check("t1_idle_n8",  32'(bus.BUSY),      32'd0);
        tick();                                   // N+9
        check("t1_popped",   32'(bus.OUT_VALID), 32'd0);

        // Back-to-back jobs with IN_VALID held
        pop_cyc.delete();
        offer(4'd15, 4'd15, 20, a0);
        offer(4'd0,  4'd9,  20, a1);
        offer(4'd1,  4'd1,  20, a2);
        check("t2_gap01", 32'(a1 - a0), 32'd8);
        check("t2_gap12", 32'(a2 - a1), 32'd8);
        drain(30);
        check("t2_npops", 32'(pop_cyc.size()), 32'd3);
        if (pop_cyc.size() == 3) begin
            check("t2_lat0",  32'(pop_cyc[0] - a0),         32'd8);
            check("t2_pgap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd8);
            check("t2_pgap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd8);
        end

        // FIFO full back-pressure
        bus.OUT_READY = 1'b0;
        offer(4'd2, 4'd3, 20, acc);
        offer(4'd4, 4'd5, 20, acc);
        bus.IN_A = 4'd6; bus.IN_B = 4'd7; bus.IN_VALID = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.IN_READY) rose = 1'b1;
            tick();
        end
        check("t3_ready_held_low", 32'(rose),          32'd0);
        check("t3_queued",         32'(sb.size()),     32'd2);
        check("t3_out_valid",      32'(bus.OUT_VALID), 32'd1);
        bus.OUT_READY = 1'b1;                     // first pop at end of this cycle
        tick();
        check("t3_ready_after_pop", 32'(bus.IN_READY),  32'd1);
        check("t3_second_head",     32'(bus.OUT_VALID), 32'd1);
        tick();
        bus.IN_VALID = 1'b0;
        check("t3_empty",     32'(bus.OUT_VALID), 32'd0);
        check("t3_start",     32'(bus.MUL_START), 32'd1);
        drain(30);

        // Watchdog timeout with a hung multiplier
        hung = 1'b1;
        check("t4_err_cnt0", 32'(bus.ERR_CNT), 32'd0);
        offer(4'd3, 4'd5, 20, acc);               // now N+1
        ticks(16);                                // N+17
        check("t4_valid_n17", 32'(bus.OUT_VALID), 32'd0);
        tick();                                   // N+18
        check("t4_valid_n18", 32'(bus.OUT_VALID), 32'd1);
        check("t4_out_err",   32'(bus.OUT_ERR),   32'd1);
        check("t4_out_p",     32'(bus.OUT_P),     32'd0);
        check("t4_err_cnt1",  32'(bus.ERR_CNT),   32'd1);
        for (int i = 0; i < 254; i++) offer(4'(i), 4'(i + 1), 40, acc);
        drain(40);
        check("t4_err_cnt255", 32'(bus.ERR_CNT), 32'd255);
        offer(4'd9, 4'd9, 40, acc);
        drain(40);
        check("t4_err_cnt_sat", 32'(bus.ERR_CNT), 32'd255);
        hung = 1'b0;

        // Stale READY through LOAD/SETTLE, true READY arrives late
        offer(4'd2, 4'd2, 20, acc);
        drain(30);
        hold_stale = 1'b1;
        lat        = 9;
        offer(4'd7, 4'd6, 20, acc);               // now N+1
        ticks(10);                                // N+11
        check("t5_valid_n11", 32'(bus.OUT_VALID), 32'd0);
        tick();                                   // N+12
        check("t5_valid_n12", 32'(bus.OUT_VALID), 32'd1);
        check("t5_out_p",     32'(bus.OUT_P),     32'h2A);
        check("t5_out_err",   32'(bus.OUT_ERR),   32'd0);
        drain(10);
        hold_stale = 1'b0;
        lat        = 5;

        // Reset during RUN with a result pending
        bus.OUT_READY = 1'b0;
        offer(4'd5, 4'd5, 20, acc);
        ticks(8);
        check("t6_pending", 32'(bus.OUT_VALID), 32'd1);
        offer(4'd2, 4'd3, 20, acc);               // now N+1
        ticks(3);                                 // N+4, RUN
        RSTN = 1'b0;
        #1;
        check("t6_rst_valid",   32'(bus.OUT_VALID), 32'd0);
        check("t6_rst_busy",    32'(bus.BUSY),      32'd0);
        check("t6_rst_err_cnt", 32'(bus.ERR_CNT),   32'd0);
        sb.delete();
        tick();
        RSTN = 1'b1;
        tick();
        bus.OUT_READY = 1'b1;
        offer(4'd7, 4'd9, 20, acc);               // now N+1
        ticks(7);                                 // N+8
        check("t6_valid", 32'(bus.OUT_VALID), 32'd1);
        check("t6_out_p", 32'(bus.OUT_P),     32'h3F);
        drain(10);

        // START drops asynchronously when reset hits the LOAD cycle
        offer(4'd1, 4'd2, 20, acc);               // LOAD
        check("t7_start_load", 32'(bus.MUL_START), 32'd1);
        RSTN = 1'b0;
        #1;
        check("t7_start_async", 32'(bus.MUL_START), 32'd0);
        check("t7_mul_a_clr",   32'(bus.MUL_A),     32'd0);
        sb.delete();
        tick();
        RSTN = 1'b1;
        ticks(2);
        check("t7_idle", 32'(bus.BUSY), 32'd0);

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
